// File: rtl/ram_march_bist.sv
// ram_march_bist
// Built-in self-test sequencer for a 2^ADDR_W x DATA_W enable-strobed RAM.
// Runs a three-phase March test and reports pass/fail plus the first failing
// location:
//   P0: ascending,  write PATTERN
//   P1: ascending,  read expecting PATTERN, then write ~PATTERN
//   P2: descending, read expecting ~PATTERN
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request, sampled only in IDLE
//   busy              high while a run is in progress
//   done              one-cycle pulse when a run ends (pass or abort)
//   pass              result of the last run
//   fail_addr/data    address and read value of the first mismatch
//   ram_address, ram_write_data, ram_write_enable, ram_read_enable
//                     RAM access port (all registered)
//   ram_read_data     RAM registered read data

module ram_march_bist #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  input  logic [DATA_W-1:0] ram_read_data
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, RD_SETUP, RD_STROBE, RD_CHECK, DONE
  } state_t;

  typedef enum logic [1:0] {P0, P1, P2} phase_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              pass_d;
  logic [ADDR_W-1:0] fail_addr_d;
  logic [DATA_W-1:0] fail_data_d;
  logic              we_d, re_d, busy_d, done_d;
  logic [DATA_W-1:0] expected;

  // NOTE: every variable gets a default before the case statement so no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = ram_address;
    wdata_d     = ram_write_data;
    pass_d      = pass;
    fail_addr_d = fail_addr;
    fail_data_d = fail_data;
    expected    = (phase_q == P1) ? PATTERN : ~PATTERN;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WR_SETUP;
          phase_d     = P0;
          addr_d      = '0;
          wdata_d     = PATTERN;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      WR_SETUP: state_d = WR_STROBE;
      WR_STROBE: begin
        if (ram_address == ADDR_MAX) begin
          // End of an ascending sweep: P0 wraps to 0 for P1, P1 hands the
          // all-ones address straight to the descending P2.
          state_d = RD_SETUP;
          if (phase_q == P0) begin
            phase_d = P1;
            addr_d  = '0;
          end else begin
            phase_d = P2;
          end
        end else begin
          addr_d  = ram_address + 1'b1;
          state_d = (phase_q == P0) ? WR_SETUP : RD_SETUP;
        end
      end
      RD_SETUP:  state_d = RD_STROBE;
      RD_STROBE: state_d = RD_CHECK;
      RD_CHECK: begin
        if (ram_read_data != expected) begin
          fail_addr_d = ram_address;
          fail_data_d = ram_read_data;
          pass_d      = 1'b0;
          state_d     = DONE;
        end else if (phase_q == P1) begin
          // Read-then-write on the same address.
          wdata_d = ~PATTERN;
          state_d = WR_SETUP;
        end else if (ram_address == '0) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = ram_address - 1'b1;
          state_d = RD_SETUP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    we_d   = (state_d == WR_STROBE);
    re_d   = (state_d == RD_STROBE);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      phase_q          <= P0;
      ram_address      <= '0;
      ram_write_data   <= '0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_addr        <= '0;
      fail_data        <= '0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      ram_address      <= addr_d;
      ram_write_data   <= wdata_d;
      ram_write_enable <= we_d;
      ram_read_enable  <= re_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      fail_addr        <= fail_addr_d;
      fail_data        <= fail_data_d;
    end
  end

endmodule
